// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port, level-sensitive RAM.
//   Port 0 is the instruction-fetch requester and port 1 is the data requester.
//   Each access is a three-cycle sequence:
//     1. grant: the RAM address, data and write enable are loaded.
//     2. access: the RAM settles, read data is captured and done pulses.
//     3. release: the write enable is low and the address is still held.
//   Because the write strobe always falls before the address moves, the
//   level-sensitive RAM never sees an address change while writing.
//
// Macro RAM_ARB_RR_EN:
//   defined   - ties go to the port that did not win last (round robin).
//   undefined - ties always go to port 0 (fixed priority).
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   pN_req/we/addr/wdata               request; held until pN_gnt
//   pN_gnt                             one-cycle pulse: request accepted
//   pN_done                            one-cycle pulse: access complete
//   pN_rdata                           read data, updated when a read completes
//   busy                               high whenever not idle
//   ram_address/write_enable/data_in   drive the attached ram
//   ram_data_out                       data returned by the attached ram
module ram_arbiter #(
   parameter int unsigned addr_bits = 16,
   parameter int unsigned data_bits = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 p0_req,
   input  logic                 p0_we,
   input  logic [addr_bits-1:0] p0_addr,
   input  logic [data_bits-1:0] p0_wdata,
   output logic                 p0_gnt,
   output logic                 p0_done,
   output logic [data_bits-1:0] p0_rdata,
   input  logic                 p1_req,
   input  logic                 p1_we,
   input  logic [addr_bits-1:0] p1_addr,
   input  logic [data_bits-1:0] p1_wdata,
   output logic                 p1_gnt,
   output logic                 p1_done,
   output logic [data_bits-1:0] p1_rdata,
   output logic                 busy,
   output logic [addr_bits-1:0] ram_address,
   output logic                 ram_write_enable,
   output logic [data_bits-1:0] ram_data_in,
   input  logic [data_bits-1:0] ram_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

   state_t               state, state_nxt;
   logic                 last_winner;
   logic                 owner;
   logic                 op_we;
   logic                 win;
   logic                 any_req;
   logic                 sel_we;
   logic [addr_bits-1:0] sel_addr;
   logic [data_bits-1:0] sel_wdata;

   assign any_req = p0_req | p1_req;

`ifdef RAM_ARB_RR_EN
   // On a tie, the port that lost the previous arbitration wins.
   always_comb begin
      win = 1'b0;
      if (p0_req && p1_req)
         win = ~last_winner;
      else
         win = p1_req;
   end
`else
   // Port 0 wins whenever it requests. last_winner is still tracked but is
   // not consulted under fixed priority.
   logic last_winner_unused;
   assign last_winner_unused = last_winner;

   always_comb begin
      win = 1'b0;
      win = ~p0_req;
   end
`endif

   always_comb begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
      if (win) begin
         sel_we    = p1_we;
         sel_addr  = p1_addr;
         sel_wdata = p1_wdata;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_address      <= '0;
         ram_data_in      <= '0;
         ram_write_enable <= 1'b0;
         p0_gnt           <= 1'b0;
         p1_gnt           <= 1'b0;
         p0_done          <= 1'b0;
         p1_done          <= 1'b0;
         p0_rdata         <= '0;
         p1_rdata         <= '0;
         busy             <= 1'b0;
         last_winner      <= 1'b1;
         owner            <= 1'b0;
         op_we            <= 1'b0;
      end else begin
         p0_gnt  <= 1'b0;
         p1_gnt  <= 1'b0;
         p0_done <= 1'b0;
         p1_done <= 1'b0;
         busy    <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               if (any_req) begin
                  ram_address      <= sel_addr;
                  ram_data_in      <= sel_wdata;
                  ram_write_enable <= sel_we;
                  owner            <= win;
                  op_we            <= sel_we;
                  last_winner      <= win;
                  if (win)
                     p1_gnt <= 1'b1;
                  else
                     p0_gnt <= 1'b1;
               end
            end
            ACCESS: begin
               // The address stays put here and through RELEASE; only the
               // strobe drops.
               ram_write_enable <= 1'b0;
               if (owner) begin
                  p1_done <= 1'b1;
                  if (!op_we) p1_rdata <= ram_data_out;
               end else begin
                  p0_done <= 1'b1;
                  if (!op_we) p0_rdata <= ram_data_out;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// transaction-level reference model (expected memory, winner policy, per-port
// read data). A behavioural level-sensitive RAM is attached to the RAM port.
module tb_ram_arbiter;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          p0_req = 1'b0, p0_we = 1'b0;
   logic [AW-1:0] p0_addr = '0;
   logic [DW-1:0] p0_wdata = '0;
   logic          p0_gnt, p0_done;
   logic [DW-1:0] p0_rdata;
   logic          p1_req = 1'b0, p1_we = 1'b0;
   logic [AW-1:0] p1_addr = '0;
   logic [DW-1:0] p1_wdata = '0;
   logic          p1_gnt, p1_done;
   logic [DW-1:0] p1_rdata;
   logic          busy;
   logic [AW-1:0] ram_address;
   logic          ram_write_enable;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;

   always #5 clk = ~clk;

   ram_arbiter #(.addr_bits(AW), .data_bits(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
      .busy(busy), .ram_address(ram_address), .ram_write_enable(ram_write_enable),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // Initial RAM contents; 0x1234 is preloaded with 0x3C.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 16'h1234) return 8'h3C;
      return (a[7:0] * 8'd37) ^ a[15:8];
   endfunction

   // Behavioural RAM: combinational read, written while write_enable is high.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign ram_data_out = mem[ram_address];
   initial begin
      for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
      forever begin
         @(posedge clk);
         if (ram_write_enable === 1'b1) mem[ram_address] = ram_data_in;
      end
   end

   // Reference model state
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] ref_rdata [2];
   bit            m_last;
   int            n_checks = 0;
   int            n_pass = 0;

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   function automatic int pick(input bit r0, input bit r1);
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
`ifdef RAM_ARB_RR_EN
      return m_last ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      p0_req = 1'b0;
      p1_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
   endtask

   // Serve one access starting from idle, with the requests currently driven.
   task automatic serve(output int w);
      logic          we_s;
      logic [AW-1:0] a_s;
      logic [DW-1:0] d_s;
      w = pick(p0_req, p1_req);
      if (w == 0) begin we_s = p0_we; a_s = p0_addr; d_s = p0_wdata; end
      else        begin we_s = p1_we; a_s = p1_addr; d_s = p1_wdata; end
      step();
      chk("gnt0", p0_gnt, w == 0);
      chk("gnt1", p1_gnt, w == 1);
      chk("busy_gnt", busy, 1);
      chk("addr_gnt", ram_address, a_s);
      chk("we_gnt", ram_write_enable, we_s);
      chk("din_gnt", ram_data_in, d_s);
      chk("done_in_gnt", {p0_done, p1_done}, 0);
      m_last = w[0];
      if (w == 0) p0_req = 1'b0; else p1_req = 1'b0;
      step();
      chk("done0", p0_done, w == 0);
      chk("done1", p1_done, w == 1);
      chk("gnt_in_done", {p0_gnt, p1_gnt}, 0);
      chk("we_done", ram_write_enable, 0);
      chk("addr_done", ram_address, a_s);
      chk("busy_done", busy, 1);
      if (!we_s) ref_rdata[w] = ref_rd(a_s);
      else       ref_mem[int'(a_s)] = d_s;
      chk("rdata0", p0_rdata, ref_rdata[0]);
      chk("rdata1", p1_rdata, ref_rdata[1]);
      step();
      chk("busy_idle", busy, 0);
      chk("we_rel", ram_write_enable, 0);
      chk("addr_rel", ram_address, a_s);
      chk("gnt_rel", {p0_gnt, p1_gnt}, 0);
      chk("done_rel", {p0_done, p1_done}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      int mode;
      m_last = 1'b1;
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;

      // Reset values
      #1;
      chk("rst_addr", ram_address, 0);
      chk("rst_din", ram_data_in, 0);
      chk("rst_we", ram_write_enable, 0);
      chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
      chk("rst_done", {p0_done, p1_done}, 0);
      chk("rst_rdata0", p0_rdata, 0);
      chk("rst_rdata1", p1_rdata, 0);
      chk("rst_busy", busy, 0);
      do_reset();

      // p1 write 0x0010 = 0xA5, then p1 read back
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0010; p1_wdata = 8'hA5;
      serve(w);
      p1_req = 1'b1; p1_we = 1'b0;
      serve(w);
      chk("p1_readback", p1_rdata, 8'hA5);

      // Continuous contention from reset: RR alternates, fixed always p0
      do_reset();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'($urandom_range(0, 15));
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'($urandom_range(0, 15));
      for (int k = 0; k < 6; k++) begin
         serve(w);
         if (w == 0) begin p0_req = 1'b1; p0_addr = 16'($urandom_range(0, 15)); end
         else        begin p1_req = 1'b1; p1_addr = 16'($urandom_range(0, 15)); end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      step();
      chk("withdraw_gnt", {p0_gnt, p1_gnt}, 0);
      chk("withdraw_busy", busy, 0);

      // Same-address contention: p0 reads preloaded 0x3C, then p1 writes 0x7E
      do_reset();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h1234;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h1234; p1_wdata = 8'h7E;
      serve(w);
      chk("same_first_p0", p0_rdata, 8'h3C);
      serve(w);
      p0_req = 1'b1;
      serve(w);
      chk("same_after_wr", p0_rdata, 8'h7E);

      // Reset during ACCESS of a p1 write
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h00FF; p1_wdata = 8'h99;
      step();
      chk("mid_gnt", p1_gnt, 1);
      chk("mid_we", ram_write_enable, 1);
      p1_req = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", ram_write_enable, 0);
      chk("mid_rst_gnt", {p0_gnt, p1_gnt}, 0);
      chk("mid_rst_done", {p0_done, p1_done}, 0);
      chk("mid_rst_busy", busy, 0);
      step();
      chk("mid_no_done", p1_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0003;
      serve(w);

      // p0 pulse during a busy p1 access is withdrawn
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0005;
      step();
      chk("pulse_p1_gnt", p1_gnt, 1);
      p1_req = 1'b0;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0020; p0_wdata = 8'hEE;
      step();
      chk("pulse_p1_done", p1_done, 1);
      chk("pulse_no_gnt_a", p0_gnt, 0);
      ref_rdata[1] = ref_rd(16'h0005);
      chk("pulse_p1_rdata", p1_rdata, ref_rdata[1]);
      p0_req = 1'b0;
      step();
      chk("pulse_idle", busy, 0);
      step();
      chk("pulse_no_gnt_b", p0_gnt, 0);
      chk("pulse_busy", busy, 0);
      chk("pulse_we", ram_write_enable, 0);
      chk("pulse_addr", ram_address, 16'h0005);
      chk("pulse_rdata0", p0_rdata, ref_rdata[0]);
      chk("pulse_mem", mem[16'h0020], ref_rd(16'h0020));

      // Randomized mixed traffic on a small address window
      for (int k = 0; k < 24; k++) begin
         mode = int'($urandom_range(0, 2));
         if (mode != 1) begin
            p0_req = 1'b1; p0_we = 1'($urandom_range(0, 1));
            p0_addr = 16'($urandom_range(0, 15)); p0_wdata = 8'($urandom);
         end
         if (mode != 0) begin
            p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
            p1_addr = 16'($urandom_range(0, 15)); p1_wdata = 8'($urandom);
         end
         serve(w);
         if (p0_req || p1_req) serve(w);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller for the shared single-port `ram` block: instruction-fetch port (p0) and data port (p1).
- Registers a single RAM access at a time and sequences `address`, `write_enable` and `data_in` safely. The RAM is level-sensitive, so `address` never changes while `write_enable` is high.
- Returns read data with a done pulse and arbitrates contention between the two ports.

Parameters:
- addr_bits, 16, RAM address width; must match the attached `ram`.
- data_bits, 8, RAM data width; must match the attached `ram`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata until p0_gnt.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  addr_bits  port 0 address.
- p0_wdata  in  data_bits  port 0 write data.
- p0_gnt  out  1  one-cycle pulse: port 0 request accepted.
- p0_done  out  1  one-cycle pulse: port 0 access complete.
- p0_rdata  out  data_bits  port 0 read data; valid when p0_done is high for a read; holds until next p0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as p0, for port 1.
- busy  out  1  high in any state other than IDLE.
- ram_address  out  addr_bits  to `ram` `address`.
- ram_write_enable  out  1  to `ram` `write_enable`.
- ram_data_in  out  data_bits  to `ram` `data_in`.
- ram_data_out  in  data_bits  from `ram` `data_out`.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0: ram_address, ram_data_in, ram_write_enable, gnt, done, rdata, busy.
  - last_winner=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RELEASE. All outputs are registered.
- IDLE:
  - If neither req is high, stay in IDLE; RAM outputs hold their values.
  - Otherwise select the winner. At the next edge: load ram_address/ram_data_in from the winner, ram_write_enable = winner's we, pN_gnt=1 (one cycle), latch owner and op, last_winner=owner, state→ACCESS.
- ACCESS: RAM settles combinationally.
  - At the next edge: for a read, capture ram_data_out into pN_rdata.
  - Set pN_done=1 (one cycle) for both reads and writes.
  - ram_write_enable←0; ram_address held; state→RELEASE.
- RELEASE:
  - ram_write_enable=0 and address held for one cycle, so the write strobe falls before the address moves.
  - Next edge: state→IDLE.
- Latency and throughput:
  - req sampled at edge E → gnt visible after E → done visible after E+1.
  - Back-to-back requests are serviced at one access per 3 cycles.
  - A request presented while busy waits; it is not lost as long as req stays asserted.
- Arbitration (RAM_ARB_RR_EN defined):
  - Only one port requesting → that port wins.
  - Both requesting → the port ≠ last_winner wins.
- Requester rules:
  - A requester may change addr/we/wdata or drop req only in or after its gnt cycle.
  - Dropping req before gnt withdraws the request; no access occurs.
  - Changing addr/we/wdata before gnt while keeping req high: the values sampled at the winning edge are used.
- gnt and done never assert for both ports in the same cycle.
- Widths are fixed at addr_bits/data_bits; no arithmetic beyond the 1-bit last_winner toggle.
- Reset mid-operation:
  - Asynchronous reset forces ram_write_enable=0 immediately and returns to IDLE.
  - A write interrupted in ACCESS may or may not have landed in the RAM; requesters must reissue.
  - No done pulse is produced for an interrupted access.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin tie-break via last_winner, as described above.
- Undefined: fixed priority, port 0 always wins ties. last_winner is still updated but ignored; port 1 may starve under continuous p0_req.

Test Plan:
- p1 write addr=0x0010 data=0xA5, then p1 read 0x0010 → p1_gnt one cycle after req, p1_done the next cycle, p1_rdata=0xA5; ram_write_enable high exactly one cycle with ram_address=0x0010 throughout, including RELEASE.
- From reset, p0 and p1 read simultaneously and continuously, with the macro defined → grants alternate p0, p1, p0, p1 every 3 cycles; busy stays high except one IDLE cycle between accesses.
- Same stimulus with the macro undefined → p0 granted on every access, p1_gnt never asserts while p0_req is held.
- p0 read 0x1234 (preloaded 0x3C) while p1 writes 0x1234 with 0x7E, both in the same cycle → with RR from reset, p0 goes first and reads 0x3C; p1 writes next; a subsequent p0 read returns 0x7E.
- rst_n driven low during ACCESS of a p1 write → ram_write_enable, gnt, done and busy go 0 immediately without a clock; no p1_done; after release, a p0 read completes normally.
- p0_req pulsed for one cycle while a p1 access is busy, then dropped → no p0_gnt, no RAM access for p0, p0_rdata unchanged.
